obi_atop_executor: RTL and testbench
====================================

OBI_ATOP_EXECUTOR -- requirements
Module: obi_atop_executor

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, OBI address width.
REQ-002 SHALL have parameter DataWidth, default 32, OBI and memory data width; only 32 is supported.
REQ-003 SHALL have parameter IdWidth, default 1, transaction ID width.
REQ-004 SHALL have port clk_i, input, 1, single clock.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports req_i in 1, gnt_o out 1, addr_i in AddrWidth, we_i in 1, be_i in DataWidth/8, wdata_i in DataWidth, aid_i in IdWidth, atop_i in 6 (OBI atop code); together these form the OBI A channel (subordinate side).
REQ-007 SHALL have ports rvalid_o out 1, rready_i in 1, rdata_o out DataWidth, rid_o out IdWidth, err_o out 1; together these form the OBI R channel.
REQ-008 SHALL have ports mem_req_o out 1, mem_gnt_i in 1, mem_addr_o out AddrWidth, mem_we_o out 1, mem_be_o out DataWidth/8, mem_wdata_o out DataWidth, mem_rvalid_i in 1, mem_rdata_i in DataWidth; together these form the downstream plain-memory port.

Function
REQ-009 SHALL accept one transaction at a time: gnt_o = req_i AND state==IDLE; on acceptance, latch addr, we, be, wdata, aid and atop.
REQ-010 SHALL use states IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP.
REQ-011 Plain read (atop=0x00, we=0) SHALL follow the path IDLE->RD->RD_WAIT->RESP, and rdata_o SHALL equal the captured mem_rdata_i.
REQ-012 Plain write (atop=0x00, we=1) SHALL follow the path IDLE->WR->WR_WAIT->RESP, with mem_wdata_o=wdata and mem_be_o=be, and rdata_o SHALL be 0.
REQ-013 AMO codes (SWAP 0x21, ADD 0x20, XOR 0x24, AND 0x2C, OR 0x28, MIN 0x30, MAX 0x34, MINU 0x38, MAXU 0x3C) SHALL follow the path IDLE->RD->RD_WAIT->WR->WR_WAIT->RESP, regardless of we.
REQ-014 For an AMO, the write data SHALL be f(old, wdata) per the opcode: ADD wraps modulo 2^DataWidth; MIN/MAX are two's-complement signed; MINU/MAXU are unsigned; rdata_o SHALL be the old value.
REQ-015 Memory-port write data SHALL use the latched be; reads SHALL drive mem_be_o all-ones.
REQ-016 In RD and WR, mem_req_o SHALL be 1 with stable address, we and data until mem_gnt_i; the FSM SHALL advance on the cycle mem_gnt_i=1.
REQ-017 In RD_WAIT and WR_WAIT, the FSM SHALL advance on mem_rvalid_i=1; exactly one mem_rvalid_i is expected per memory grant.
REQ-018 In RESP, rvalid_o=1 and rdata_o, rid_o, err_o SHALL be held stable until rready_i=1, then return to IDLE; no grant is given in the RESP cycle.
REQ-019 An unsupported atop code SHALL make no memory access, go IDLE->RESP with err_o=1 and rdata_o=0.
REQ-020 Minimum latency: plain access grant-to-rvalid_o is 3 cycles with zero-wait memory; an AMO is 5 cycles.

Reset
REQ-021 On rst_i=1 at a clock edge, state SHALL go to IDLE, the reservation SHALL be cleared, and all latched fields SHALL be cleared.
REQ-022 During and immediately after reset: gnt_o=0 (while rst_i=1), rvalid_o=0, err_o=0, rdata_o=0, rid_o=0, mem_req_o=0, mem_we_o=0.
REQ-023 Reset mid-transaction SHALL abandon the transaction without a response; the bench SHALL also reset the memory.

Configuration
REQ-024 Macro OBI_ATOP_EXECUTOR_LRSC_EN SHALL control LR/SC support as follows.
- Defined: AMOLR (0x22) behaves as a plain read and sets the reservation {valid, word address}.
- Defined: AMOSC (0x23) with a valid, matching reservation writes wdata and returns rdata 0; otherwise it makes no memory access and returns rdata 1 (IDLE->RESP).
- Defined: any SC clears the reservation; any write or AMO to the reserved word also clears it.
- Undefined: 0x22 and 0x23 are treated as unsupported (REQ-019), and no reservation register exists.

Verification
REQ-025 Read at 0x10, with memory holding 0xDEADBEEF and aid=1 -> rvalid_o after 3 cycles, rdata_o=0xDEADBEEF, rid_o=1, err_o=0.
REQ-026 AMOADD at 0x20, memory holding 0xFFFFFFFF, wdata 2 -> memory becomes 0x00000001, rdata_o=0xFFFFFFFF.
REQ-027 AMOMIN with old 0x00000005 and wdata 0x80000000 -> memory becomes 0x80000000; AMOMINU on the same values leaves memory at 0x00000005.
REQ-028 With the macro defined: LR at 0x40, then SC at 0x40 with wdata 7 -> SC rdata_o=0 and memory=7; a second SC -> rdata_o=1, memory unchanged, no mem_req_o.
REQ-029 atop=0x3F -> err_o=1, rdata_o=0, no mem_req_o; rready_i held low for 4 cycles -> rvalid_o and the response stay stable.
REQ-030 Assert rst_i during RD_WAIT -> next cycle all outputs are 0, and a new read completes normally.

Source files
------------

// File: rtl/obi_atop_executor.sv
// OBI subordinate that executes atomic (atop) transactions on a plain memory port, one at a time.
// Optional LR/SC reservation support is compiled in with `define OBI_ATOP_EXECUTOR_LRSC_EN.
module obi_atop_executor #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // OBI A channel
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IdWidth-1:0]     aid_i,
  input  logic [5:0]             atop_i,
  // OBI R channel
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IdWidth-1:0]     rid_o,
  output logic                   err_o,
  // plain memory port
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  localparam logic [5:0] AtopNone = 6'h00;
  localparam logic [5:0] AtopAdd  = 6'h20;
  localparam logic [5:0] AtopSwap = 6'h21;
  localparam logic [5:0] AtopXor  = 6'h24;
  localparam logic [5:0] AtopOr   = 6'h28;
  localparam logic [5:0] AtopAnd  = 6'h2C;
  localparam logic [5:0] AtopMin  = 6'h30;
  localparam logic [5:0] AtopMax  = 6'h34;
  localparam logic [5:0] AtopMinu = 6'h38;
  localparam logic [5:0] AtopMaxu = 6'h3C;
`ifdef OBI_ATOP_EXECUTOR_LRSC_EN
  localparam logic [5:0] AtopLr   = 6'h22;
  localparam logic [5:0] AtopSc   = 6'h23;
`endif

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP} state_e;

  // What an accepted request turns into: which memory phase it starts with, or none at all.
  typedef enum logic [2:0] {K_RD, K_WR, K_AMO, K_SC_FAIL, K_ERR} kind_e;

  state_e               state_q;
  kind_e                kind;
  logic [5:0]           atop_q;
  logic [BeWidth-1:0]   be_q;
  logic [DataWidth-1:0] wdata_q;

  function automatic logic is_amo(input logic [5:0] op);
    case (op)
      AtopSwap, AtopAdd, AtopXor, AtopAnd, AtopOr,
      AtopMin, AtopMax, AtopMinu, AtopMaxu: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic [DataWidth-1:0] amo_result(input logic [5:0]           op,
                                                      input logic [DataWidth-1:0] old_v,
                                                      input logic [DataWidth-1:0] operand);
    logic [DataWidth-1:0] res;
    res = operand;
    case (op)
      AtopAdd:  res = old_v + operand;
      AtopXor:  res = old_v ^ operand;
      AtopAnd:  res = old_v & operand;
      AtopOr:   res = old_v | operand;
      AtopMin:  res = ($signed(old_v) < $signed(operand)) ? old_v : operand;
      AtopMax:  res = ($signed(old_v) > $signed(operand)) ? old_v : operand;
      AtopMinu: res = (old_v < operand) ? old_v : operand;
      AtopMaxu: res = (old_v > operand) ? old_v : operand;
      default:  res = operand;
    endcase
    return res;
  endfunction

`ifdef OBI_ATOP_EXECUTOR_LRSC_EN
  logic                 resv_valid_q;
  logic [AddrWidth-3:0] resv_addr_q;
  logic                 resv_hit;

  assign resv_hit = resv_valid_q && (resv_addr_q == addr_i[AddrWidth-1:2]);
`endif

  // Reset is excluded so nothing is granted in the very cycle that abandons a transaction.
  assign gnt_o = req_i && (state_q == IDLE) && !rst_i;

  always_comb begin
    // NOTE: kind gets a default before any branch so no latch is inferred.
    kind = K_ERR;
    if (atop_i == AtopNone) begin
      kind = we_i ? K_WR : K_RD;
    end else if (is_amo(atop_i)) begin
      kind = K_AMO;
`ifdef OBI_ATOP_EXECUTOR_LRSC_EN
    end else if (atop_i == AtopLr) begin
      kind = K_RD;
    end else if (atop_i == AtopSc) begin
      kind = resv_hit ? K_WR : K_SC_FAIL;
`endif
    end
  end

  // NOTE: every register below uses non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      atop_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      rid_o       <= '0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
`ifdef OBI_ATOP_EXECUTOR_LRSC_EN
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_o) begin
            atop_q      <= atop_i;
            be_q        <= be_i;
            wdata_q     <= wdata_i;
            rid_o       <= aid_i;
            err_o       <= (kind == K_ERR);
            rdata_o     <= (kind == K_SC_FAIL) ? {{(DataWidth-1){1'b0}}, 1'b1} : '0;
            mem_addr_o  <= addr_i;
            mem_we_o    <= (kind == K_WR);
            mem_be_o    <= (kind == K_WR) ? be_i : '1;
            mem_wdata_o <= (kind == K_WR) ? wdata_i : '0;
            case (kind)
              K_RD, K_AMO: begin
                state_q   <= RD;
                mem_req_o <= 1'b1;
              end
              K_WR: begin
                state_q   <= WR;
                mem_req_o <= 1'b1;
              end
              default: begin
                state_q  <= RESP;
                rvalid_o <= 1'b1;
              end
            endcase
`ifdef OBI_ATOP_EXECUTOR_LRSC_EN
            if (atop_i == AtopLr) begin
              resv_valid_q <= 1'b1;
              resv_addr_q  <= addr_i[AddrWidth-1:2];
            end else if (atop_i == AtopSc || ((kind == K_WR || kind == K_AMO) && resv_hit)) begin
              resv_valid_q <= 1'b0;
            end
`endif
          end
        end
        RD: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_o <= mem_rdata_i;
            if (is_amo(atop_q)) begin
              // The old value is returned; the combined value goes back out in the write phase.
              state_q     <= WR;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_be_o    <= be_q;
              mem_wdata_o <= amo_result(atop_q, mem_rdata_i, wdata_q);
            end else begin
              state_q  <= RESP;
              rvalid_o <= 1'b1;
            end
          end
        end
        WR: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            state_q   <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_rvalid_i) begin
            state_q  <= RESP;
            rvalid_o <= 1'b1;
          end
        end
        RESP: begin
          if (rready_i) begin
            rvalid_o <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_atop_executor.sv
// Self-checking bench for obi_atop_executor: directed cases plus randomized transactions
// against a word-level memory/reservation model. Honours OBI_ATOP_EXECUTOR_LRSC_EN.
module tb_obi_atop_executor;

  localparam int NWORDS = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic [0:0]  aid_i = '0;
  logic [5:0]  atop_i = '0;
  logic        rvalid_o;
  logic        rready_i = 1'b0;
  logic [31:0] rdata_o;
  logic [0:0]  rid_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b1;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  obi_atop_executor #(.AddrWidth(32), .DataWidth(32), .IdWidth(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .aid_i(aid_i), .atop_i(atop_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // memory device behind the DUT, and the reference model's view of the same words
  logic [31:0] mem_dev [NWORDS];
  logic [31:0] ref_mem [NWORDS];
  bit          ref_resv_valid;
  logic [4:0]  ref_resv_idx;
  bit          zero_wait = 1'b1;
  int          mem_acc = 0;

  // DUT outputs sampled on the falling edge
  logic        s_gnt, s_rvalid, s_err, s_mem_req, s_mem_we;
  logic [31:0] s_rdata;
  logic [0:0]  s_rid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic init_mem();
    logic [31:0] v;
    for (int i = 0; i < NWORDS; i++) begin
      v = $urandom;
      mem_dev[i] = v;
      ref_mem[i] = v;
    end
    ref_resv_valid = 1'b0;
    ref_resv_idx   = '0;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    mem_dev[idx] = v;
    ref_mem[idx] = v;
  endtask

  // One clock: sample outputs at negedge, then act as the memory right after the rising edge.
  task automatic tick();
    logic hs, w;
    logic [4:0]  idx;
    logic [3:0]  b;
    logic [31:0] d;
    @(negedge clk_i);
    s_gnt = gnt_o; s_rvalid = rvalid_o; s_rdata = rdata_o; s_rid = rid_o;
    s_err = err_o; s_mem_req = mem_req_o; s_mem_we = mem_we_o;
    hs  = mem_req_o && mem_gnt_i && !rst_i;
    idx = mem_addr_o[6:2]; w = mem_we_o; b = mem_be_o; d = mem_wdata_o;
    @(posedge clk_i);
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (hs) begin
      mem_acc++;
      mem_rdata_i  = mem_dev[idx];
      mem_rvalid_i = 1'b1;
      if (w) mem_dev[idx] = merge(mem_dev[idx], d, b);
    end
    mem_gnt_i = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
  endtask

  // Arithmetic of each AMO; returns 0 for codes that are not AMOs.
  function automatic bit amo_apply(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r);
    r = b;
    case (op)
      6'h21: r = b;
      6'h20: r = a + b;
      6'h24: r = a ^ b;
      6'h2C: r = a & b;
      6'h28: r = a | b;
      6'h30: r = (int'(a) < int'(b)) ? a : b;
      6'h34: r = (int'(a) > int'(b)) ? a : b;
      6'h38: r = (a < b) ? a : b;
      6'h3C: r = (a > b) ? a : b;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Reference outcome of one transaction: response fields and number of memory accesses.
  task automatic model(input logic [5:0] atop, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] e_rdata, output logic e_err, output int e_acc);
    logic [4:0]  idx;
    logic [31:0] old_v, new_v;
    idx = addr[6:2];
    old_v = ref_mem[idx];
    e_rdata = '0; e_err = 1'b0; e_acc = 0;
    if (atop == 6'h00 && !we) begin
      e_rdata = old_v; e_acc = 1;
    end else if (atop == 6'h00) begin
      ref_mem[idx] = merge(old_v, wdata, be); e_acc = 1;
      if (ref_resv_valid && ref_resv_idx == idx) ref_resv_valid = 1'b0;
    end else if (amo_apply(atop, old_v, wdata, new_v)) begin
      ref_mem[idx] = merge(old_v, new_v, be); e_rdata = old_v; e_acc = 2;
      if (ref_resv_valid && ref_resv_idx == idx) ref_resv_valid = 1'b0;
`ifdef OBI_ATOP_EXECUTOR_LRSC_EN
    end else if (atop == 6'h22) begin
      e_rdata = old_v; e_acc = 1; ref_resv_valid = 1'b1; ref_resv_idx = idx;
    end else if (atop == 6'h23) begin
      if (ref_resv_valid && ref_resv_idx == idx) begin
        ref_mem[idx] = merge(old_v, wdata, be); e_acc = 1;
      end else begin
        e_rdata = 32'd1;
      end
      ref_resv_valid = 1'b0;
`endif
    end else begin
      e_err = 1'b1;
    end
  endtask

  // Full transaction; chk_lat enables the exact zero-wait latency check.
  task automatic run_txn(input string tag, input logic [5:0] atop, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input logic [0:0] aid, input int hold, input bit chk_lat);
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_acc, acc0, n;
    model(atop, we, addr, wdata, be, e_rdata, e_err, e_acc);
    acc0 = mem_acc;
    req_i = 1'b1; atop_i = atop; we_i = we; addr_i = addr; wdata_i = wdata;
    be_i = be; aid_i = aid; rready_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!s_gnt && n < 100);
    check({tag, "_gnt"}, 32'(s_gnt), 32'd1);
    // scramble the A channel so only latched fields can produce a correct result
    req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; atop_i = 6'($urandom);
    we_i = 1'($urandom); be_i = 4'($urandom); aid_i = 1'($urandom);
    n = 0;
    do begin tick(); n++; end while (!s_rvalid && n < 200);
    check({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
    if (chk_lat) check({tag, "_lat"}, 32'(n), 32'(1 + 2 * e_acc));
    check({tag, "_rdata"}, s_rdata, e_rdata);
    check({tag, "_rid"}, 32'(s_rid), 32'(aid));
    check({tag, "_err"}, 32'(s_err), 32'(e_err));
    for (int h = 0; h < hold; h++) begin
      req_i = 1'b1; atop_i = 6'h00; we_i = 1'b0; addr_i = '0;
      tick();
      check({tag, "_hold_gnt"}, 32'(s_gnt), 32'd0);
      check({tag, "_hold_rvalid"}, 32'(s_rvalid), 32'd1);
      check({tag, "_hold_rdata"}, s_rdata, e_rdata);
      check({tag, "_hold_err"}, 32'(s_err), 32'(e_err));
    end
    req_i = 1'b0;
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0;
    check({tag, "_acc"}, 32'(mem_acc - acc0), 32'(e_acc));
    check({tag, "_mem"}, mem_dev[addr[6:2]], ref_mem[addr[6:2]]);
  endtask

  logic [5:0] atop_pool [17] = '{6'h00, 6'h00, 6'h00, 6'h21, 6'h20, 6'h24, 6'h2C, 6'h28,
                                 6'h30, 6'h34, 6'h38, 6'h3C, 6'h22, 6'h23, 6'h3F, 6'h01, 6'h10};

  initial begin
    int n;
    logic [5:0] op;
    logic [4:0] idx;
    init_mem();

    // reset state, with a request pending that must not be granted
    rst_i = 1'b1; req_i = 1'b1; atop_i = 6'h00; we_i = 1'b0; addr_i = 32'h10;
    tick();
    tick();
    check("rst_gnt", 32'(s_gnt), 32'd0);
    check("rst_rvalid", 32'(s_rvalid), 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_rid", 32'(s_rid), 32'd0);
    check("rst_err", 32'(s_err), 32'd0);
    check("rst_mem_req", 32'(s_mem_req), 32'd0);
    check("rst_mem_we", 32'(s_mem_we), 32'd0);
    req_i = 1'b0; rst_i = 1'b0;
    tick();

    // directed cases, zero-wait memory
    zero_wait = 1'b1; mem_gnt_i = 1'b1;
    preload(4, 32'hDEADBEEF);
    run_txn("read", 6'h00, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 0, 1'b1);
    preload(8, 32'hFFFFFFFF);
    run_txn("amoadd", 6'h20, 1'b0, 32'h20, 32'd2, 4'hF, 1'b0, 0, 1'b1);
    check("amoadd_val", mem_dev[8], 32'h00000001);
    preload(9, 32'h5);
    run_txn("amomin", 6'h30, 1'b1, 32'h24, 32'h80000000, 4'hF, 1'b0, 0, 1'b1);
    check("amomin_val", mem_dev[9], 32'h80000000);
    preload(9, 32'h5);
    run_txn("amominu", 6'h38, 1'b0, 32'h24, 32'h80000000, 4'hF, 1'b0, 0, 1'b1);
    check("amominu_val", mem_dev[9], 32'h00000005);
    run_txn("wr_be", 6'h00, 1'b1, 32'h28, 32'hA5A5A5A5, 4'b0101, 1'b1, 1, 1'b1);
`ifdef OBI_ATOP_EXECUTOR_LRSC_EN
    run_txn("lr", 6'h22, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 0, 1'b1);
    run_txn("sc1", 6'h23, 1'b1, 32'h40, 32'd7, 4'hF, 1'b0, 0, 1'b1);
    check("sc1_val", mem_dev[16], 32'd7);
    run_txn("sc2", 6'h23, 1'b1, 32'h40, 32'd9, 4'hF, 1'b0, 0, 1'b1);
    check("sc2_val", mem_dev[16], 32'd7);
`else
    run_txn("lr_unsup", 6'h22, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 0, 1'b1);
    run_txn("sc_unsup", 6'h23, 1'b1, 32'h40, 32'd7, 4'hF, 1'b1, 0, 1'b1);
`endif
    run_txn("bad_atop", 6'h3F, 1'b0, 32'h0C, 32'h1234, 4'hF, 1'b1, 4, 1'b1);

    // reset while waiting for read data abandons the transaction
    req_i = 1'b1; atop_i = 6'h00; we_i = 1'b0; addr_i = 32'h10; aid_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!s_gnt && n < 100);
    check("abort_gnt", 32'(s_gnt), 32'd1);
    req_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mem_rvalid_i = 1'b0;
    init_mem();
    tick();
    check("abort_rvalid", 32'(s_rvalid), 32'd0);
    check("abort_rdata", s_rdata, 32'd0);
    check("abort_rid", 32'(s_rid), 32'd0);
    check("abort_err", 32'(s_err), 32'd0);
    check("abort_mem_req", 32'(s_mem_req), 32'd0);
    check("abort_mem_we", 32'(s_mem_we), 32'd0);
    run_txn("after_rst", 6'h00, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 0, 1'b1);

    // randomized traffic: first half zero-wait with exact latency, second half with grant stalls
    for (int t = 0; t < 240; t++) begin
      zero_wait = (t < 120);
      op  = atop_pool[$urandom_range(0, 16)];
      idx = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      run_txn("rand", op, 1'($urandom), {25'b0, idx, 2'b00}, $urandom,
              4'($urandom), 1'($urandom), $urandom_range(0, 2), zero_wait);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
